// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline definitions: MDU sequencer state encoding, cycle-count defaults
// and the counter preload helper.
package mips_defs;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int MULT_CYC_DEF = 4;
  localparam int DIV_CYC_DEF  = 32;
  localparam int STAT_W_DEF   = 16;
  localparam int MD_CNT_W     = 6;

  // Preload so that BUSY lasts exactly the requested number of cycles, counting down to 0.
  function automatic logic [MD_CNT_W-1:0] md_load(input logic div, input int mult_cyc,
                                                  input int div_cyc);
    return MD_CNT_W'(div ? div_cyc - 1 : mult_cyc - 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_md_sequencer.sv
// Multi-cycle mult/div sequencer: IDLE -> BUSY (N cycles) -> DONE (1 cycle) -> IDLE.
module md_sequencer
  import mips_defs::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic done
);

  md_state_t             state;
  logic [MD_CNT_W-1:0]   cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= md_load(div, MULT_CYC, DIV_CYC);
            busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            state <= MD_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MD_DONE: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use, branch-operand and MDU stalls, wrong-path
// flush, and a saturating stall-cycle statistic.
module hazard_ctrl_unit
  import mips_defs::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int STAT_W   = STAT_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [4:0]        RsE,
  input  logic [4:0]        RtE,
  input  logic [4:0]        WriteRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [4:0]        WriteRegM,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              JumpD,
  input  logic              MdStartD,
  input  logic              MdDivD,
  input  logic              MfHiLoD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MdBusy,
  output logic              MdDone,
  output logic [STAT_W-1:0] StallCycles
);

  logic lwstall;
  logic brstall;
  logic mdstall;
  logic stall;
  logic unused_fwd;

  // RsE is only present so forwarding logic can share this port list.
  assign unused_fwd = ^{RsE};

  assign lwstall = MemtoRegE & ((RsD == RtE) | (RtD == RtE)) & (RtE != 5'd0);

  assign brstall = BranchD &
                   ((RegWriteE & (WriteRegE != 5'd0) & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                    (MemtoRegM & (WriteRegM != 5'd0) & ((WriteRegM == RsD) | (WriteRegM == RtD))));

  assign mdstall = (MdStartD | MfHiLoD) & MdBusy;
  assign stall   = lwstall | brstall | mdstall;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  // A pending redirect waits until the stall clears so the branch sees settled operands.
  assign FlushD = (PCSrcD | JumpD) & ~stall;

  md_sequencer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_sequencer (
    .clk   (CLK),
    .rst   (RST),
    .start (MdStartD & ~stall),
    .div   (MdDivD),
    .busy  (MdBusy),
    .done  (MdDone)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      StallCycles <= '0;
    end else if (stall && !(&StallCycles)) begin
      StallCycles <= StallCycles + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic
// against a cycle-countdown reference model of the MDU.
module tb_hazard_ctrl_unit;

  localparam int MULT_CYC = 4;
  localparam int DIV_CYC  = 32;
  localparam int STAT_W   = 16;
  localparam int SAT      = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4:0]        RsD, RtD, RsE, RtE, WriteRegE, WriteRegM;
  logic              RegWriteE, MemtoRegE, MemtoRegM, BranchD, PCSrcD, JumpD;
  logic              MdStartD, MdDivD, MfHiLoD;
  logic              StallF, StallD, FlushD, FlushE, MdBusy, MdDone;
  logic [STAT_W-1:0] StallCycles;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles remaining until the MDU is free again (BUSY + DONE), and the stat count.
  int md_rem  = 0;
  int exp_cnt = 0;

  logic obs_stall;
  logic obs_done;

  hazard_ctrl_unit #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .STAT_W   (STAT_W)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .RsD         (RsD),
    .RtD         (RtD),
    .RsE         (RsE),
    .RtE         (RtE),
    .WriteRegE   (WriteRegE),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .WriteRegM   (WriteRegM),
    .MemtoRegM   (MemtoRegM),
    .BranchD     (BranchD),
    .PCSrcD      (PCSrcD),
    .JumpD       (JumpD),
    .MdStartD    (MdStartD),
    .MdDivD      (MdDivD),
    .MfHiLoD     (MfHiLoD),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .MdBusy      (MdBusy),
    .MdDone      (MdDone),
    .StallCycles (StallCycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0; WriteRegE = '0; WriteRegM = '0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    MdStartD = 1'b0; MdDivD = 1'b0; MfHiLoD = 1'b0;
  endtask

  function automatic logic reads(input logic [4:0] dst);
    return (dst != 5'd0) && (dst == RsD || dst == RtD);
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle(input string tag);
    logic st, fd, busy, done;
    @(negedge clk);
    st = (MemtoRegE && reads(RtE)) ||
         (BranchD && ((RegWriteE && reads(WriteRegE)) || (MemtoRegM && reads(WriteRegM)))) ||
         ((MdStartD || MfHiLoD) && md_rem > 0);
    fd   = (PCSrcD || JumpD) && !st;
    busy = md_rem > 0;
    done = md_rem == 1;
    obs_stall = StallD;
    obs_done  = MdDone;
    check({tag, "/ctl"}, 32'({StallF, StallD, FlushD, FlushE, MdBusy, MdDone}),
          32'({st, st, fd, st, busy, done}));
    check({tag, "/cnt"}, 32'(StallCycles), 32'(exp_cnt));
    @(posedge clk);
    if (!rst) begin
      if (md_rem > 0) md_rem--;
      else if (MdStartD && !st) md_rem = (MdDivD ? DIV_CYC : MULT_CYC) + 1;
      if (st && exp_cnt < SAT) exp_cnt++;
    end
    #1;
  endtask

  initial begin
    int n, d;
    clear_inputs();
    #12;
    check("reset_ctl", 32'({StallF, StallD, FlushD, FlushE, MdBusy, MdDone}), 32'd0);
    check("reset_cnt", 32'(StallCycles), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Load-use, then the same pattern on $0.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    cycle("lw_use");
    RtE = 5'd0; RsD = 5'd0;
    cycle("lw_r0");
    clear_inputs();

    // Branch operand hazard with a taken branch, then the redirect once it clears.
    BranchD = 1'b1; PCSrcD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd3; RtD = 5'd3;
    cycle("br_haz");
    RegWriteE = 1'b0;
    cycle("br_redirect");
    MemtoRegM = 1'b1; WriteRegM = 5'd0; RtD = 5'd0;
    cycle("br_mem_r0");
    MemtoRegM = 1'b1; WriteRegM = 5'd7; RsD = 5'd7;
    cycle("br_mem_haz");
    clear_inputs();
    JumpD = 1'b1;
    cycle("jump");
    clear_inputs();

    // Div then a waiting mfhi: 32 BUSY + 1 DONE stalled cycles, one done pulse.
    MdStartD = 1'b1; MdDivD = 1'b1;
    cycle("div_issue");
    MdStartD = 1'b0; MdDivD = 1'b0; MfHiLoD = 1'b1;
    n = 0; d = 0;
    for (int i = 0; i < 100; i++) begin
      cycle("div_mfhi");
      n += int'(obs_stall);
      d += int'(obs_done);
      if (!obs_stall) break;
    end
    check("div_stall_len", 32'(n), 32'(DIV_CYC + 1));
    check("div_done_pulses", 32'(d), 32'd1);
    clear_inputs();

    // Back-to-back mult: second start waits out BUSY + DONE, then issues.
    MdStartD = 1'b1;
    cycle("mult1_issue");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle("mult2_wait");
      if (!obs_stall) break;
      n++;
    end
    check("mult2_stall_len", 32'(n), 32'(MULT_CYC + 1));
    MdStartD = 1'b0;
    cycle("mult2_busy");
    repeat (MULT_CYC + 2) cycle("mult2_drain");

    // Reset mid-div: MDU and counter clear asynchronously.
    MdStartD = 1'b1; MdDivD = 1'b1;
    cycle("div2_issue");
    clear_inputs();
    repeat (10) cycle("div2_run");
    rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(MdBusy), 32'd0);
    check("rst_async_cnt", 32'(StallCycles), 32'd0);
    md_rem = 0; exp_cnt = 0;
    cycle("in_reset");
    rst = 1'b0;
    MfHiLoD = 1'b1;
    cycle("mfhi_after_rst");
    check("mfhi_after_rst_stall", 32'(obs_stall), 32'd0);
    clear_inputs();

    // Randomized traffic over a small register pool so hazards collide often.
    for (int i = 0; i < 1500; i++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); MemtoRegE = ($urandom_range(0, 3) == 0);
      MemtoRegM = ($urandom_range(0, 3) == 0); BranchD = ($urandom_range(0, 2) == 0);
      PCSrcD = 1'($urandom_range(0, 1)); JumpD = ($urandom_range(0, 7) == 0);
      MdStartD = ($urandom_range(0, 7) == 0); MdDivD = ($urandom_range(0, 3) == 0);
      MfHiLoD = ($urandom_range(0, 5) == 0);
      cycle("rand");
    end
    clear_inputs();

    // Hold a load-use stall long enough to saturate the statistic.
    MemtoRegE = 1'b1; RtE = 5'd5; RsD = 5'd5;
    repeat (SAT + 3) cycle("sat");
    check("sat_final", 32'(StallCycles), 32'(SAT));
    clear_inputs();
    cycle("sat_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
